// File: rtl/data_mem_access_ctrl.sv
// Word load/store front-end for the DataMemory RAM: checks addresses,
// covers the RAM read latency and returns a one-cycle response strobe.
module data_mem_access_ctrl #(
  parameter int RAM_ADDR_W   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic accept;
  logic req_err;

  assign req_err = (req_addr[1:0] != 2'b00)
                 | (req_addr[31:RAM_ADDR_W+2] != '0);

  // Gated by rst so no write or address can leak out while in reset.
  assign accept = (state_q == IDLE) & req_valid & ~rst;

  assign ram_din   = req_wdata;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_valid & err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          err_d = req_err;
          if (req_err) begin
            state_d = DONE;
          end else begin
            addr_d   = req_addr[RAM_ADDR_W+1:2];
            ram_addr = req_addr[RAM_ADDR_W+1:2];
            if (req_write) begin
              ram_we  = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = CNT_W'(READ_LATENCY - 1);
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = ram_dout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
